// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the RV32I multicycle control path
// Purpose: FSM state enum, ALU operation codes, opcodes, mux select encodings
// and ALU decoder op classes. The ALU imports the same codes so both ends agree.
// No ports (package).
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_t;

    // Operation class handed to the ALU decoder; only R/I/BRANCH look at funct bits.
    typedef enum logic [2:0] {
        OPC_ADD,
        OPC_PASS_B,
        OPC_R,
        OPC_I,
        OPC_BRANCH
    } op_class_t;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b0100;
    localparam logic [3:0] ALU_SLTU   = 4'b1100;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_XOR    = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b1000;
    localparam logic [3:0] ALU_SRL    = 4'b1010;
    localparam logic [3:0] ALU_SRA    = 4'b1110;
    localparam logic [3:0] ALU_GE     = 4'b1011;
    localparam logic [3:0] ALU_EQ     = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] RES_ALUOUT   = 2'd0;
    localparam logic [1:0] RES_MEM      = 2'd1;
    localparam logic [1:0] RES_ALU      = 2'd2;

    // Branch decision from the ALU zero flag; the ALU code chosen per funct3
    // makes ZERO mean either "condition true" or "condition false".
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        case (funct3)
            3'b000, 3'b001, 3'b111: branch_taken = zero;
            3'b100, 3'b101, 3'b110: branch_taken = !zero;
            default:                branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALU operation decoder
// Purpose: maps op class, funct3 and funct7[5] to the 4-bit ALU code.
// Ports: op_class (in), funct3 (in, 3), funct7_5 (in, 1), alu_control (out, 4).
module alu_decoder
    import cpu_pkg::*;
(
    input  op_class_t   op_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output logic [3:0]  alu_control
);

    logic [3:0] arith_code;

    // Shared R/I arithmetic table; SUB only exists for register-register ops.
    always_comb begin
        arith_code = ALU_ADD;
        case (funct3)
            3'b000: arith_code = (op_class == OPC_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: arith_code = ALU_SLL;
            3'b010: arith_code = ALU_SLT;
            3'b011: arith_code = ALU_SLTU;
            3'b100: arith_code = ALU_XOR;
            3'b101: arith_code = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: arith_code = ALU_OR;
            3'b111: arith_code = ALU_AND;
            default: arith_code = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (op_class)
            OPC_ADD:    alu_control = ALU_ADD;
            OPC_PASS_B: alu_control = ALU_PASS_B;
            OPC_R,
            OPC_I:      alu_control = arith_code;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  alu_control = ALU_SUB;
                    3'b001:  alu_control = ALU_EQ;
                    3'b100:  alu_control = ALU_SLT;
                    3'b101:  alu_control = ALU_GE;
                    3'b110,
                    3'b111:  alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:    alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle RV32I control FSM
// Purpose: sequences fetch/decode/execute/memory/writeback, drives ALU code,
// datapath mux selects and strobes, counts retired instructions.
// Ports: CLK, RESET (sync, active high), INSTR[31:0], ZERO, MEM_READY in;
// ALU_CONTROL[3:0], ALU_SRC_A[1:0], ALU_SRC_B[1:0], RESULT_SRC[1:0], ADDR_SRC,
// IR_WRITE, PC_WRITE, REG_WRITE, MEM_READ, MEM_WRITE, INSTR_CNT out.
// Build option: ILLEGAL_TRAP_EN makes ILLEGAL terminal and adds the ILLEGAL output.
module control_multiciclo
    import cpu_pkg::*;
#(
    parameter bit RESET_PC_SEL = 1'b0,
    parameter int INSTR_CNT_W  = 32
)
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            INSTR,
    input  logic                   ZERO,
    input  logic                   MEM_READY,
    output logic [3:0]             ALU_CONTROL,
    output logic [1:0]             ALU_SRC_A,
    output logic [1:0]             ALU_SRC_B,
    output logic [1:0]             RESULT_SRC,
    output logic                   ADDR_SRC,
    output logic                   IR_WRITE,
    output logic                   PC_WRITE,
    output logic                   REG_WRITE,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [INSTR_CNT_W-1:0] INSTR_CNT
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                   ILLEGAL
`endif
);

    state_t     state;
    state_t     next_state;
    op_class_t  op_class;
    logic [3:0] dec_alu;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_instr_bits;

    assign opcode   = INSTR[6:0];
    assign funct3   = INSTR[14:12];
    assign funct7_5 = INSTR[30];
    assign unused_instr_bits = ^{INSTR[31], INSTR[29:15], INSTR[11:7]};

    alu_decoder u_alu_decoder (
        .op_class    (op_class),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (dec_alu)
    );

    // Reset forces ADD so the ALU sees a quiet code while the FSM recovers.
    assign ALU_CONTROL = RESET ? ALU_ADD : dec_alu;

`ifdef ILLEGAL_TRAP_EN
    assign ILLEGAL = (state == S_ILLEGAL);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_FETCH;
            INSTR_CNT <= '0;
        end else begin
            state <= next_state;
            // Every instruction, including an illegal NOP, ends by re-entering FETCH.
            if (state != S_FETCH && next_state == S_FETCH)
                INSTR_CNT <= INSTR_CNT + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        op_class   = OPC_ADD;
        ALU_SRC_A  = SRC_A_PC;
        ALU_SRC_B  = SRC_B_RS2;
        RESULT_SRC = RES_ALUOUT;
        ADDR_SRC   = 1'b0;
        IR_WRITE   = 1'b0;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;

        case (state)
            S_FETCH: begin
                MEM_READ  = 1'b1;
                ADDR_SRC  = RESET_PC_SEL;
                ALU_SRC_A = SRC_A_PC;
                ALU_SRC_B = SRC_B_FOUR;
                IR_WRITE  = MEM_READY;
                PC_WRITE  = MEM_READY;
                if (MEM_READY)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute PC-relative target into ALUOUT for branch/JAL.
                ALU_SRC_A = SRC_A_OLD_PC;
                ALU_SRC_B = SRC_B_IMM;
                case (opcode)
                    OP_R:               next_state = S_EXEC_R;
                    OP_I:               next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
                    OP_BRANCH:          next_state = S_BRANCH;
                    OP_JAL:             next_state = S_JAL;
                    OP_LUI:             next_state = S_LUI;
                    OP_AUIPC:           next_state = S_AUIPC;
                    default:            next_state = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                ALU_SRC_A  = SRC_A_RS1;
                ALU_SRC_B  = SRC_B_RS2;
                op_class   = OPC_R;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALU_SRC_A  = SRC_A_RS1;
                ALU_SRC_B  = SRC_B_IMM;
                op_class   = OPC_I;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                REG_WRITE  = 1'b1;
                RESULT_SRC = RES_ALUOUT;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALU_SRC_A  = SRC_A_RS1;
                ALU_SRC_B  = SRC_B_IMM;
                next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MEM_READ = 1'b1;
                ADDR_SRC = 1'b1;
                if (MEM_READY)
                    next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                REG_WRITE  = 1'b1;
                RESULT_SRC = RES_MEM;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                MEM_WRITE = 1'b1;
                ADDR_SRC  = 1'b1;
                if (MEM_READY)
                    next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALU_SRC_A  = SRC_A_RS1;
                ALU_SRC_B  = SRC_B_RS2;
                RESULT_SRC = RES_ALUOUT;
                op_class   = OPC_BRANCH;
                PC_WRITE   = branch_taken(funct3, ZERO);
                next_state = S_FETCH;
            end
            S_JAL: begin
                // PC takes the registered target via ALUOUT while the live ALU
                // computes OLD_PC + 4 for rd, so the result mux shows the ALU.
                PC_WRITE   = 1'b1;
                REG_WRITE  = 1'b1;
                ALU_SRC_A  = SRC_A_OLD_PC;
                ALU_SRC_B  = SRC_B_FOUR;
                RESULT_SRC = RES_ALU;
                next_state = S_FETCH;
            end
            S_LUI: begin
                ALU_SRC_B  = SRC_B_IMM;
                op_class   = OPC_PASS_B;
                RESULT_SRC = RES_ALU;
                REG_WRITE  = 1'b1;
                next_state = S_FETCH;
            end
            S_AUIPC: begin
                ALU_SRC_A  = SRC_A_OLD_PC;
                ALU_SRC_B  = SRC_B_IMM;
                RESULT_SRC = RES_ALU;
                REG_WRITE  = 1'b1;
                next_state = S_FETCH;
            end
            S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                next_state = S_ILLEGAL;
`else
                next_state = S_FETCH;
`endif
            end
            default: next_state = S_FETCH;
        endcase

        // The reset cycle must not disturb the datapath even if the FSM was
        // mid-instruction.
        if (RESET) begin
            ALU_SRC_A  = SRC_A_PC;
            ALU_SRC_B  = SRC_B_RS2;
            RESULT_SRC = RES_ALUOUT;
            ADDR_SRC   = RESET_PC_SEL;
            IR_WRITE   = 1'b0;
            PC_WRITE   = 1'b0;
            REG_WRITE  = 1'b0;
            MEM_READ   = 1'b0;
            MEM_WRITE  = 1'b0;
        end
    end

endmodule
